// File: rtl/armleocpu_lsu.sv
// Load/store unit: one AXI4 single-beat transaction per request, with lane steering and exception mapping.
// Optional watchdog with DRAIN recovery is enabled by defining ARMLEOCPU_LSU_TIMEOUT_EN.
module armleocpu_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_load,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [4:0]              req_rd,
  output logic                    stall_o,
  output logic                    done_o,
  output logic                    rd_write,
  output logic [4:0]              rd_waddr,
  output logic [DATA_WIDTH-1:0]   rd_wdata,
  output logic                    exc_valid,
  output logic [3:0]              exc_code,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic [0:0]              M_AXI_BUSER,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [1:0]              M_AXI_ARBURST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic [0:0]              M_AXI_RUSER
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("armleocpu_lsu: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

`ifdef ARMLEOCPU_LSU_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, RD, WR, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

  state_t                state;
  logic                  addr_done, data_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [4:0]            rd_q;
  logic                  store_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] sh;
    sh = data >> {off, 3'b000};
    case (f3)
      3'b000:  return DATA_WIDTH'($signed(sh[7:0]));
      3'b001:  return DATA_WIDTH'($signed(sh[15:0]));
      3'b010:  return DATA_WIDTH'($signed(sh[31:0]));
      3'b100:  return DATA_WIDTH'(sh[7:0]);
      3'b101:  return DATA_WIDTH'(sh[15:0]);
      3'b110:  return DATA_WIDTH'(sh[31:0]);
      default: return sh;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lane(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] size);
    case (size)
      2'd0:    return {NB{d[7:0]}};
      2'd1:    return {(NB/2){d[15:0]}};
      2'd2:    return {(NB/4){d[31:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [NB-1:0] store_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  logic       acc, acc_bad, illegal, misal;
  logic [3:0] acc_code;
  logic       ar_hs, aw_hs, w_hs, r_hs, b_hs, resp_hs;
  logic [1:0] resp;
  logic       resp_user;
  logic [3:0] resp_code;
  logic       tmo, draining;

  always_comb begin
    illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
              ((DATA_WIDTH == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
    case (req_funct3[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      2'd3:    misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
    // done_o gates acceptance so a request still held during its completion cycle is not taken twice
    acc      = (state == IDLE) && req_valid && (req_load || req_store) && !done_o;
    acc_bad  = illegal || misal;
    acc_code = illegal ? 4'd2 : (req_store ? 4'd6 : 4'd4);
  end

  assign ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
  assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
  assign b_hs      = M_AXI_BVALID && M_AXI_BREADY;
  assign resp_hs   = r_hs || b_hs;
  assign resp      = r_hs ? M_AXI_RRESP : M_AXI_BRESP;
  assign resp_user = r_hs ? M_AXI_RUSER[0] : M_AXI_BUSER[0];
  assign resp_code = (resp == 2'b00) ? 4'd0 :
                     resp_user ? (store_q ? 4'd15 : 4'd13) : (store_q ? 4'd7 : 4'd5);

`ifdef ARMLEOCPU_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  assign draining = (state == DRAIN);
  assign tmo      = (state == RD || state == WR) && !resp_hs &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (acc)                      cnt <= '0;
    else if (state == RD || state == WR) cnt <= cnt + CNT_W'(1);
  end
`else
  assign draining = 1'b0;
  assign tmo      = 1'b0;
`endif

  assign stall_o = (state != IDLE) || (req_valid && (req_load || req_store) && !done_o);

  assign M_AXI_ARADDR  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign M_AXI_AWADDR  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign M_AXI_ARSIZE  = 3'(OFF_W);
  assign M_AXI_AWSIZE  = 3'(OFF_W);
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_done     <= 1'b0;
      data_done     <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      done_o        <= 1'b0;
      rd_write      <= 1'b0;
      exc_valid     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rd_write  <= 1'b0;
      exc_valid <= 1'b0;
      if (state == IDLE) begin
        if (acc) begin
          if (acc_bad) begin
            done_o    <= 1'b1;
            exc_valid <= 1'b1;
          end else begin
            addr_done <= 1'b0;
            data_done <= 1'b0;
            if (req_store) begin
              state         <= WR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end else begin
              state         <= RD;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
      end else begin
        if (ar_hs) begin
          M_AXI_ARVALID <= 1'b0;
          addr_done     <= 1'b1;
          M_AXI_RREADY  <= 1'b1;
        end
        if (aw_hs) begin
          M_AXI_AWVALID <= 1'b0;
          addr_done     <= 1'b1;
        end
        if (w_hs) begin
          M_AXI_WVALID <= 1'b0;
          data_done    <= 1'b1;
        end
        // data_done is only ever set by stores, so loads never raise BREADY
        if ((addr_done || aw_hs) && (data_done || w_hs))
          M_AXI_BREADY <= 1'b1;
        if (resp_hs) begin
          M_AXI_RREADY <= 1'b0;
          M_AXI_BREADY <= 1'b0;
          state        <= IDLE;
          if (!draining) begin
            done_o    <= 1'b1;
            rd_write  <= (resp == 2'b00) && (rd_q != 5'd0) && !store_q;
            exc_valid <= (resp != 2'b00);
          end
        end else if (tmo) begin
          done_o    <= 1'b1;
          exc_valid <= 1'b1;
`ifdef ARMLEOCPU_LSU_TIMEOUT_EN
          state     <= DRAIN;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      addr_q   <= req_addr;
      f3_q     <= req_funct3;
      rd_q     <= req_rd;
      store_q  <= req_store;
      wdata_q  <= store_lane(req_wdata, req_funct3[1:0]);
      wstrb_q  <= store_strb(req_funct3[1:0], req_addr[OFF_W-1:0]);
      exc_code <= acc_code;
    end
    if (resp_hs && !draining) begin
      rd_waddr <= rd_q;
      rd_wdata <= load_ext(M_AXI_RDATA, addr_q[OFF_W-1:0], f3_q);
      exc_code <= resp_code;
    end else if (tmo) begin
      exc_code <= store_q ? 4'd7 : 4'd5;
    end
  end

endmodule

// File: tb/tb_armleocpu_lsu.sv
// Directed bench for armleocpu_lsu: scripted AXI slave responses with hand-computed expectations.
module tb_armleocpu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        stall_o, done_o, rd_write, exc_valid;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [3:0]  exc_code;
  logic        AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0, WLAST, BVALID = 1'b0, BREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA = '0;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [7:0]  AWLEN, ARLEN;
  logic [1:0]  AWBURST, ARBURST, BRESP = '0, RRESP = '0;
  logic [3:0]  WSTRB;
  logic [0:0]  BUSER = '0, RUSER = '0;
  logic        ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;

  int n_cmp = 0;
  int n_bad = 0;

  armleocpu_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall_o(stall_o), .done_o(done_o), .rd_write(rd_write), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY), .M_AXI_AWADDR(AWADDR),
    .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWLEN(AWLEN), .M_AXI_AWBURST(AWBURST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_WDATA(WDATA),
    .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARLEN(ARLEN), .M_AXI_ARBURST(ARBURST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY), .M_AXI_RDATA(RDATA),
    .M_AXI_RRESP(RRESP), .M_AXI_RUSER(RUSER)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_araddr,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic ruser, input logic exp_wr, input logic [31:0] exp_data,
                          input logic exp_exc, input logic [3:0] exp_code);
    @(negedge clk);
    req_valid = 1; req_load = 1; req_store = 0; req_funct3 = f3; req_addr = addr; req_rd = rd;
    #1 chk("ld_stall_req", stall_o, 1);
    @(negedge clk);
    chk("ld_arvalid", ARVALID, 1);
    chk("ld_araddr", ARADDR, exp_araddr);
    chk("ld_arsize", ARSIZE, 2);
    chk("ld_arlen_burst", {ARLEN, ARBURST}, {8'd0, 2'b01});
    chk("ld_rready_early", RREADY, 0);
    ARREADY = 1;
    @(negedge clk);
    ARREADY = 0;
    chk("ld_arvalid_drop", ARVALID, 0);
    chk("ld_rready", RREADY, 1);
    chk("ld_done_early", done_o, 0);
    chk("ld_stall_busy", stall_o, 1);
    RVALID = 1; RDATA = rdata; RRESP = rresp; RUSER = ruser;
    @(negedge clk);
    RVALID = 0;
    chk("ld_done", done_o, 1);
    chk("ld_rd_write", rd_write, exp_wr);
    chk("ld_exc_valid", exc_valid, exp_exc);
    chk("ld_stall_done", stall_o, 0);
    if (exp_exc) chk("ld_exc_code", exc_code, exp_code);
    if (exp_wr) begin
      chk("ld_rd_wdata", rd_wdata, exp_data);
      chk("ld_rd_waddr", rd_waddr, rd);
    end
    req_valid = 0; req_load = 0;
    @(negedge clk);
    chk("ld_done_pulse", done_o, 0);
    chk("ld_rready_idle", RREADY, 0);
  endtask

  // order: 0 = W before AW, 1 = AW before W, 2 = same cycle
  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input int order, input logic [3:0] exp_strb, input logic [31:0] exp_lanes,
                           input logic [1:0] bresp, input logic buser,
                           input logic exp_exc, input logic [3:0] exp_code);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) if (exp_strb[i]) mask[i*8 +: 8] = 8'hFF;
    @(negedge clk);
    req_valid = 1; req_store = 1; req_load = 0; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = 0;
    #1 chk("st_stall_req", stall_o, 1);
    @(negedge clk);
    chk("st_awvalid", AWVALID, 1);
    chk("st_wvalid", WVALID, 1);
    chk("st_awaddr", AWADDR, {addr[31:2], 2'b00});
    chk("st_awsize", AWSIZE, 2);
    chk("st_wlast", WLAST, 1);
    chk("st_wstrb", WSTRB, exp_strb);
    chk("st_wdata", WDATA & mask, exp_lanes);
    if (order == 0) begin
      WREADY = 1;
      @(negedge clk); WREADY = 0;
      chk("st_wvalid_drop", WVALID, 0);
      chk("st_awvalid_hold", AWVALID, 1);
      chk("st_bready_early", BREADY, 0);
      AWREADY = 1;
      @(negedge clk); AWREADY = 0;
    end else if (order == 1) begin
      AWREADY = 1;
      @(negedge clk); AWREADY = 0;
      chk("st_awvalid_drop", AWVALID, 0);
      chk("st_wvalid_hold", WVALID, 1);
      chk("st_bready_early", BREADY, 0);
      WREADY = 1;
      @(negedge clk); WREADY = 0;
    end else begin
      AWREADY = 1; WREADY = 1;
      @(negedge clk); AWREADY = 0; WREADY = 0;
    end
    chk("st_valids_done", {AWVALID, WVALID}, 2'b00);
    chk("st_bready", BREADY, 1);
    chk("st_done_early", done_o, 0);
    BVALID = 1; BRESP = bresp; BUSER = buser;
    @(negedge clk);
    BVALID = 0;
    chk("st_done", done_o, 1);
    chk("st_exc_valid", exc_valid, exp_exc);
    chk("st_rd_write", rd_write, 0);
    if (exp_exc) chk("st_exc_code", exc_code, exp_code);
    req_valid = 0; req_store = 0;
    @(negedge clk);
    chk("st_done_pulse", done_o, 0);
    chk("st_bready_idle", BREADY, 0);
  endtask

  task automatic run_bad(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [3:0] exp_code);
    @(negedge clk);
    req_valid = 1; req_store = is_store; req_load = !is_store; req_funct3 = f3; req_addr = addr;
    #1 chk("bad_stall_req", stall_o, 1);
    @(negedge clk);
    chk("bad_done", done_o, 1);
    chk("bad_exc_valid", exc_valid, 1);
    chk("bad_exc_code", exc_code, exp_code);
    chk("bad_no_bus", {ARVALID, AWVALID, WVALID}, 3'b000);
    chk("bad_rd_write", rd_write, 0);
    chk("bad_stall_done", stall_o, 0);
    req_valid = 0; req_store = 0; req_load = 0;
    @(negedge clk);
    chk("bad_done_pulse", done_o, 0);
    chk("bad_no_bus_after", {ARVALID, AWVALID, WVALID}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first_done;
    int pulses;
    logic [3:0] tcode;

    repeat (3) @(negedge clk);
    chk("rst_valids", {ARVALID, AWVALID, WVALID}, 3'b000);
    chk("rst_readys", {RREADY, BREADY}, 2'b00);
    chk("rst_done_wr_exc", {done_o, rd_write, exc_valid}, 3'b000);
    rst_n = 1;
    @(negedge clk);
    chk("idle_stall", stall_o, 0);

    run_load(3'b000, 32'h1003, 32'h1000, 5'd5, 32'h80FFFFFF, 2'b00, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 4'd0);
    run_load(3'b101, 32'h1002, 32'h1000, 5'd7, 32'h80011234, 2'b00, 1'b0, 1'b1, 32'h00008001, 1'b0, 4'd0);
    run_load(3'b001, 32'h1002, 32'h1000, 5'd7, 32'h80011234, 2'b00, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 4'd0);
    run_load(3'b100, 32'h1001, 32'h1000, 5'd3, 32'h0000A500, 2'b00, 1'b0, 1'b1, 32'h000000A5, 1'b0, 4'd0);
    run_load(3'b010, 32'h1000, 32'h1000, 5'd0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    run_load(3'b010, 32'h1004, 32'h1004, 5'd9, 32'h12345678, 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 4'd13);
    run_load(3'b000, 32'h1000, 32'h1000, 5'd9, 32'h12345678, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 4'd5);

    run_store(3'b001, 32'h2002, 32'h00001234, 0, 4'b1100, 32'h12340000, 2'b00, 1'b0, 1'b0, 4'd0);
    run_store(3'b000, 32'h2001, 32'h000000AB, 2, 4'b0010, 32'h0000AB00, 2'b00, 1'b0, 1'b0, 4'd0);
    run_store(3'b010, 32'h2000, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 2'b10, 1'b1, 1'b1, 4'd15);
    run_store(3'b000, 32'h2003, 32'h0000005A, 2, 4'b1000, 32'h5A000000, 2'b11, 1'b0, 1'b1, 4'd7);

    run_bad(1'b0, 3'b010, 32'h1001, 4'd4);
    run_bad(1'b0, 3'b001, 32'h1003, 4'd4);
    run_bad(1'b1, 3'b010, 32'h3002, 4'd6);
    run_bad(1'b1, 3'b001, 32'h2001, 4'd6);
    run_bad(1'b0, 3'b011, 32'h1000, 4'd2);
    run_bad(1'b0, 3'b110, 32'h1000, 4'd2);
    run_bad(1'b1, 3'b100, 32'h2000, 4'd2);

    // Store whose B response is withheld.
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'b010; req_addr = 32'h2000; req_wdata = 32'h11223344;
    first_done = 0; pulses = 0; tcode = '0;
`ifdef ARMLEOCPU_LSU_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done_o) begin
        pulses++;
        if (first_done == 0) begin
          first_done = k;
          tcode = exc_code;
          chk("tmo_exc_valid", exc_valid, 1);
          req_valid = 0; req_store = 0;
        end
      end
      if (k == 1) begin AWREADY = 1; WREADY = 1; end
      if (k == 2) begin AWREADY = 0; WREADY = 0; end
    end
    chk("tmo_done_cycle", first_done, 9);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_exc_code", tcode, 7);
    chk("tmo_drain_stall", stall_o, 1);
    chk("tmo_drain_bready", BREADY, 1);
    BVALID = 1; BRESP = 2'b00;
    @(negedge clk);
    BVALID = 0;
    chk("tmo_no_second_done", done_o, 0);
    chk("tmo_idle_stall", stall_o, 0);
    chk("tmo_bready_idle", BREADY, 0);
    @(negedge clk);
    chk("tmo_no_late_done", done_o, 0);
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_o) pulses++;
      if (k == 1) begin AWREADY = 1; WREADY = 1; end
      if (k == 2) begin AWREADY = 0; WREADY = 0; end
    end
    chk("wait_no_done", pulses, 0);
    chk("wait_stall", stall_o, 1);
    chk("wait_bready", BREADY, 1);
    BVALID = 1; BRESP = 2'b00;
    @(negedge clk);
    BVALID = 0;
    chk("wait_done", done_o, 1);
    chk("wait_exc_valid", exc_valid, 0);
    req_valid = 0; req_store = 0;
    @(negedge clk);
    chk("wait_done_pulse", done_o, 0);
`endif

    // Asynchronous reset while a load address is outstanding.
    @(negedge clk);
    req_valid = 1; req_load = 1; req_funct3 = 3'b010; req_addr = 32'h1000; req_rd = 5'd4;
    @(negedge clk);
    chk("rstrd_arvalid", ARVALID, 1);
    #2 rst_n = 0;
    #1 chk("rstrd_arvalid_async", ARVALID, 0);
    chk("rstrd_rready", RREADY, 0);
    req_valid = 0; req_load = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstrd_no_done", done_o, 0);
      chk("rstrd_no_ar", ARVALID, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
